// File: rtl/branch_predictor.sv
// Gshare branch predictor: PC-xor-history indexed table of 2-bit counters,
// predicting in decode and training non-speculatively when the branch leaves EX.
module branch_predictor #(
    parameter int PHT_IDX_BITS = 10,
    parameter int GHR_BITS     = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] pcD,
    input  logic        branchD,
    input  logic        stallE,
    input  logic        flushE,
    input  logic        actual_takeE,
    output logic        pred_takeD,
    output logic        pred_takeE,
    output logic        branchE,
    output logic        mispredictE
);

    localparam int PHT_SIZE = 1 << PHT_IDX_BITS;

    logic [1:0]              pht [PHT_SIZE];
    logic [GHR_BITS-1:0]     ghr;
    logic [GHR_BITS-1:0]     ghr_next;
    logic [PHT_IDX_BITS-1:0] idxD;
    logic [PHT_IDX_BITS-1:0] idxE;
    logic [1:0]              cnt_cur;
    logic [1:0]              cnt_next;
    logic                    updE;
    logic                    unused_pc;

    assign unused_pc = ^{pcD[31:PHT_IDX_BITS+2], pcD[1:0]};

    assign idxD        = pcD[PHT_IDX_BITS+1:2] ^ PHT_IDX_BITS'(ghr);
    assign pred_takeD  = branchD & pht[idxD][1];
    assign updE        = branchE & ~stallE & ~flushE;
    assign mispredictE = branchE & (pred_takeE ^ actual_takeE);

    // A one-bit history has nothing to shift, so it simply mirrors the last outcome.
    generate
        if (GHR_BITS == 1) begin : g_ghr_one
            assign ghr_next = actual_takeE;
        end else begin : g_ghr_shift
            assign ghr_next = {ghr[GHR_BITS-2:0], actual_takeE};
        end
    endgenerate

    always_comb begin
        cnt_cur  = pht[idxE];
        cnt_next = cnt_cur;
        if (actual_takeE && cnt_cur != 2'b11) begin
            cnt_next = cnt_cur + 2'b01;
        end else if (!actual_takeE && cnt_cur != 2'b00) begin
            cnt_next = cnt_cur - 2'b01;
        end
    end

    // Training uses the index captured at prediction time, not one rebuilt from the current history.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < PHT_SIZE; i++) begin
                pht[i] <= 2'b01;
            end
            ghr <= '0;
        end else if (updE) begin
            pht[idxE] <= cnt_next;
            ghr       <= ghr_next;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            branchE    <= 1'b0;
            pred_takeE <= 1'b0;
            idxE       <= '0;
        end else if (flushE) begin
            branchE <= 1'b0;
        end else if (!stallE) begin
            branchE    <= branchD;
            pred_takeE <= pred_takeD;
            idxE       <= idxD;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: hand-traced counter and history values
// across training, saturation, history indexing, stall/flush, collision and reset.
module tb_branch_predictor;

    logic        clk;
    logic        resetn;
    logic [31:0] pcD;
    logic        branchD;
    logic        stallE;
    logic        flushE;
    logic        actual_takeE;
    logic        pred_takeD;
    logic        pred_takeE;
    logic        branchE;
    logic        mispredictE;

    int total;
    int passed;

    branch_predictor dut (
        .clk          (clk),
        .resetn       (resetn),
        .pcD          (pcD),
        .branchD      (branchD),
        .stallE       (stallE),
        .flushE       (flushE),
        .actual_takeE (actual_takeE),
        .pred_takeD   (pred_takeD),
        .pred_takeE   (pred_takeE),
        .branchE      (branchE),
        .mispredictE  (mispredictE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL timeout: got running expected finished");
        $fatal(1, "[TB] timeout");
    end

    task automatic drive(input logic b, input logic [31:0] pc, input logic st,
                         input logic fl, input logic act);
        branchD      = b;
        pcD          = pc;
        stallE       = st;
        flushE       = fl;
        actual_takeE = act;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        resetn = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick;
        tick;
        resetn = 1'b1;
    endtask

    task automatic test_reset;
        apply_reset;
        drive(1'b1, 32'h0040_0020, 1'b0, 1'b0, 1'b0);
        #3;
        total++; if (pred_takeD !== 1'b0) $display("[TB] FAIL reset_predD: got %b expected 0", pred_takeD); else passed++;
        total++; if (branchE !== 1'b0) $display("[TB] FAIL reset_branchE: got %b expected 0", branchE); else passed++;
        total++; if (pred_takeE !== 1'b0) $display("[TB] FAIL reset_predE: got %b expected 0", pred_takeE); else passed++;
        total++; if (mispredictE !== 1'b0) $display("[TB] FAIL reset_mispredict: got %b expected 0", mispredictE); else passed++;
        tick;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick;
    endtask

    // Eight taken outcomes fill the history with ones; the training branch then sits at 0x008^0xFF = 0xF7.
    task automatic test_training;
        apply_reset;
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 32'h0040_0000, 1'b0, 1'b0, 1'b0);
            tick;
            drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
            tick;
        end
        drive(1'b1, 32'h0040_0020, 1'b0, 1'b0, 1'b0);
        #3;
        total++; if (pred_takeD !== 1'b0) $display("[TB] FAIL train1_pred: got %b expected 0", pred_takeD); else passed++;
        tick;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        #3;
        total++; if (mispredictE !== 1'b1) $display("[TB] FAIL train1_mispredict: got %b expected 1", mispredictE); else passed++;
        tick;
        drive(1'b1, 32'h0040_0020, 1'b0, 1'b0, 1'b0);
        #3;
        total++; if (pred_takeD !== 1'b1) $display("[TB] FAIL train2_pred: got %b expected 1", pred_takeD); else passed++;
        tick;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        #3;
        total++; if (mispredictE !== 1'b0) $display("[TB] FAIL train2_mispredict: got %b expected 0", mispredictE); else passed++;
        tick;
        drive(1'b1, 32'h0040_0020, 1'b0, 1'b0, 1'b0);
        #3;
        total++; if (pred_takeD !== 1'b1) $display("[TB] FAIL train3_pred: got %b expected 1", pred_takeD); else passed++;
        tick;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        #3;
        total++; if (mispredictE !== 1'b1) $display("[TB] FAIL train3_mispredict: got %b expected 1", mispredictE); else passed++;
        tick;
        // History is now 0xFE, so PC 0x00400024 (0x009) lands back on entry 0xF7.
        drive(1'b1, 32'h0040_0024, 1'b0, 1'b0, 1'b0);
        #3;
        total++; if (pred_takeD !== 1'b1) $display("[TB] FAIL train4_pred: got %b expected 1", pred_takeD); else passed++;
        tick;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        tick;
    endtask

    task automatic test_saturation;
        apply_reset;
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 32'h0040_0040, 1'b0, 1'b0, 1'b0);
            #3;
            total++; if (pred_takeD !== 1'b0) $display("[TB] FAIL sat_pred%0d: got %b expected 0", k, pred_takeD); else passed++;
            tick;
            drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
            #3;
            total++; if (mispredictE !== 1'b0) $display("[TB] FAIL sat_mispredict%0d: got %b expected 0", k, mispredictE); else passed++;
            tick;
        end
    endtask

    // T at 0x005, N at 0x000^1, T at 0x007^2 leaves history 0x05 and entry 0x005 at 2'b11.
    task automatic test_ghr_index;
        apply_reset;
        drive(1'b1, 32'h0040_0014, 1'b0, 1'b0, 1'b0);
        #3;
        total++; if (pred_takeD !== 1'b0) $display("[TB] FAIL ghrA_pred: got %b expected 0", pred_takeD); else passed++;
        tick;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        #3;
        total++; if (mispredictE !== 1'b1) $display("[TB] FAIL ghrA_mispredict: got %b expected 1", mispredictE); else passed++;
        tick;
        drive(1'b1, 32'h0040_0000, 1'b0, 1'b0, 1'b0);
        #3;
        total++; if (pred_takeD !== 1'b0) $display("[TB] FAIL ghrB_pred: got %b expected 0", pred_takeD); else passed++;
        tick;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick;
        drive(1'b1, 32'h0040_001C, 1'b0, 1'b0, 1'b0);
        #3;
        total++; if (pred_takeD !== 1'b1) $display("[TB] FAIL ghrC_pred: got %b expected 1", pred_takeD); else passed++;
        tick;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        #3;
        total++; if (mispredictE !== 1'b0) $display("[TB] FAIL ghrC_mispredict: got %b expected 0", mispredictE); else passed++;
        tick;
        drive(1'b1, 32'h0040_0000, 1'b0, 1'b0, 1'b0);
        #3;
        total++; if (pred_takeD !== 1'b1) $display("[TB] FAIL ghrD_pred: got %b expected 1", pred_takeD); else passed++;
        tick;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        tick;
    endtask

    task automatic test_stall_flush;
        apply_reset;
        drive(1'b1, 32'h0040_0040, 1'b0, 1'b0, 1'b0);
        tick;
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
            #3;
            total++; if (mispredictE !== 1'b1) $display("[TB] FAIL stall_mispredict%0d: got %b expected 1", k, mispredictE); else passed++;
            tick;
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        tick;
        // One step: entry 0x010 = 2'b10, history 0x01; PC 0x00400044 maps back onto 0x010.
        drive(1'b1, 32'h0040_0044, 1'b0, 1'b0, 1'b0);
        #3;
        total++; if (pred_takeD !== 1'b1) $display("[TB] FAIL stall_step_pred: got %b expected 1", pred_takeD); else passed++;
        tick;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick;
        drive(1'b1, 32'h0040_0048, 1'b0, 1'b0, 1'b0);
        #3;
        total++; if (pred_takeD !== 1'b0) $display("[TB] FAIL stall_single_pred: got %b expected 0", pred_takeD); else passed++;
        tick;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick;

        apply_reset;
        drive(1'b1, 32'h0040_0040, 1'b0, 1'b0, 1'b0);
        tick;
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        tick;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        #3;
        total++; if (branchE !== 1'b0) $display("[TB] FAIL flush_branchE: got %b expected 0", branchE); else passed++;
        total++; if (mispredictE !== 1'b0) $display("[TB] FAIL flush_mispredict: got %b expected 0", mispredictE); else passed++;
        drive(1'b1, 32'h0040_0040, 1'b0, 1'b0, 1'b0);
        #1;
        total++; if (pred_takeD !== 1'b0) $display("[TB] FAIL flush_pht_pred: got %b expected 0", pred_takeD); else passed++;
        drive(1'b1, 32'h0040_0044, 1'b0, 1'b0, 1'b0);
        #1;
        total++; if (pred_takeD !== 1'b0) $display("[TB] FAIL flush_ghr_pred: got %b expected 0", pred_takeD); else passed++;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick;
    endtask

    // Back-to-back branches on entry 0x010 with an update and a read of it in the same cycle.
    task automatic test_back_to_back;
        apply_reset;
        drive(1'b1, 32'h0040_0040, 1'b0, 1'b0, 1'b0);
        #3;
        total++; if (pred_takeD !== 1'b0) $display("[TB] FAIL b2b_c0_pred: got %b expected 0", pred_takeD); else passed++;
        tick;
        drive(1'b1, 32'h0040_0040, 1'b0, 1'b0, 1'b1);
        #3;
        total++; if (pred_takeD !== 1'b0) $display("[TB] FAIL b2b_collision_pred: got %b expected 0", pred_takeD); else passed++;
        total++; if (mispredictE !== 1'b1) $display("[TB] FAIL b2b_c1_mispredict: got %b expected 1", mispredictE); else passed++;
        tick;
        drive(1'b1, 32'h0040_0044, 1'b0, 1'b0, 1'b0);
        #3;
        total++; if (pred_takeD !== 1'b1) $display("[TB] FAIL b2b_after_pred: got %b expected 1", pred_takeD); else passed++;
        total++; if (mispredictE !== 1'b0) $display("[TB] FAIL b2b_c2_mispredict: got %b expected 0", mispredictE); else passed++;
        tick;
        drive(1'b1, 32'h0040_0048, 1'b0, 1'b0, 1'b1);
        #3;
        total++; if (pred_takeD !== 1'b0) $display("[TB] FAIL b2b_c3_pred: got %b expected 0", pred_takeD); else passed++;
        total++; if (mispredictE !== 1'b0) $display("[TB] FAIL b2b_c3_mispredict: got %b expected 0", mispredictE); else passed++;
        tick;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        #3;
        total++; if (branchE !== 1'b1) $display("[TB] FAIL b2b_c4_branchE: got %b expected 1", branchE); else passed++;
        total++; if (pred_takeE !== 1'b0) $display("[TB] FAIL b2b_c4_predE: got %b expected 0", pred_takeE); else passed++;
        tick;
    endtask

    task automatic test_reset_midrun;
        apply_reset;
        drive(1'b1, 32'h0040_0040, 1'b0, 1'b0, 1'b0);
        tick;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        tick;
        drive(1'b1, 32'h0040_0044, 1'b0, 1'b0, 1'b0);
        #3;
        total++; if (pred_takeD !== 1'b1) $display("[TB] FAIL mid_pre_pred: got %b expected 1", pred_takeD); else passed++;
        tick;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        #3;
        total++; if (mispredictE !== 1'b1) $display("[TB] FAIL mid_pre_mispredict: got %b expected 1", mispredictE); else passed++;
        resetn = 1'b0;
        #1;
        total++; if (branchE !== 1'b0) $display("[TB] FAIL mid_branchE: got %b expected 0", branchE); else passed++;
        total++; if (pred_takeE !== 1'b0) $display("[TB] FAIL mid_predE: got %b expected 0", pred_takeE); else passed++;
        total++; if (mispredictE !== 1'b0) $display("[TB] FAIL mid_mispredict: got %b expected 0", mispredictE); else passed++;
        tick;
        resetn = 1'b1;
        drive(1'b1, 32'h0040_0044, 1'b0, 1'b0, 1'b0);
        #3;
        total++; if (pred_takeD !== 1'b0) $display("[TB] FAIL mid_post_pred44: got %b expected 0", pred_takeD); else passed++;
        drive(1'b1, 32'h0040_0040, 1'b0, 1'b0, 1'b0);
        #1;
        total++; if (pred_takeD !== 1'b0) $display("[TB] FAIL mid_post_pred40: got %b expected 0", pred_takeD); else passed++;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick;
    endtask

    initial begin
        total  = 0;
        passed = 0;
        resetn = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        test_reset;
        test_training;
        test_saturation;
        test_ghr_index;
        test_stall_flush;
        test_back_to_back;
        test_reset_midrun;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
